// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer: serialises source reads over the single regbank port,
// fires the shared ALU, then writes the result back to the destination register.
module alu_seq_ctrl #(
    parameter int REGSEL_W = 6,
    parameter int DATA_W   = 8,
    parameter int OP_W     = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_code,
    input  logic [REGSEL_W-1:0] op_dst,
    input  logic [REGSEL_W-1:0] op_src0,
    input  logic [REGSEL_W-1:0] op_src1,
    input  logic                op_imm_en,
    input  logic [DATA_W-1:0]   op_imm,
    output logic [REGSEL_W-1:0] regsel,
    input  logic [DATA_W-1:0]   reg_rdata,
    output logic [DATA_W-1:0]   reg_val,
    output logic                reg_we,
    output logic [DATA_W-1:0]   alu_op0,
    output logic [DATA_W-1:0]   alu_op1,
    output logic [OP_W-1:0]     alu_opcode,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [OP_W-1:0]     code_q;
    logic [REGSEL_W-1:0] dst_q;
    logic [REGSEL_W-1:0] src0_q;
    logic [REGSEL_W-1:0] src1_q;
    logic                imm_en_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   res_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                accept;

    assign accept = op_valid && (state == S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (op_valid) state_nxt = S_RD0;
            S_RD0:   state_nxt = imm_en_q ? S_EXEC : S_RD1;
            S_RD1:   state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready = 1'b0;
        busy     = 1'b1;
        regsel   = '0;
        reg_we   = 1'b0;
        reg_val  = '0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
            end
            S_RD0:  regsel = src0_q;
            S_RD1:  regsel = src1_q;
            S_EXEC: regsel = dst_q;
            S_WB: begin
                regsel  = dst_q;
                reg_val = res_q;
                reg_we  = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand, opcode and result latches; B is preloaded from the immediate so RD1 can be skipped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q   <= '0;
            dst_q    <= '0;
            src0_q   <= '0;
            src1_q   <= '0;
            imm_en_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                code_q   <= op_code;
                dst_q    <= op_dst;
                src0_q   <= op_src0;
                src1_q   <= op_src1;
                imm_en_q <= op_imm_en;
                if (op_imm_en) b_q <= op_imm;
            end
            if (state == S_RD0)  a_q   <= reg_rdata;
            if (state == S_RD1)  b_q   <= reg_rdata;
            if (state == S_EXEC) res_q <= alu_result;
            if (state == S_WB)   cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign alu_op0    = a_q;
    assign alu_op1    = b_q;
    assign alu_opcode = code_q;
    assign retire_cnt = cnt_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Execute-stage sequencer driving the shared ALU and the single-port register bank inside a CPU domain.
- Accepts one decoded register-register or register-immediate op via valid/ready.
- Serialises source reads over the one regsel port, fires the ALU, then writes the result back to the destination register.
- Sits between decode and the alu/regbank pair; owns regsel, reg_val, reg_we and the ALU operand/opcode inputs.

Parameters:
- REGSEL_W, 6, register select width (matches regbank regsel).
- DATA_W, 8, datapath width (ALU operands/result, register value).
- OP_W, 4, ALU opcode width.
- CNT_W, 16, retired-op counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  decoded op present.
- op_ready  out  1  controller can accept an op.
- op_code  in  OP_W  ALU opcode.
- op_dst  in  REGSEL_W  destination register.
- op_src0  in  REGSEL_W  source register A.
- op_src1  in  REGSEL_W  source register B (ignored when op_imm_en=1).
- op_imm_en  in  1  operand B from op_imm.
- op_imm  in  DATA_W  immediate operand B.
- regsel  out  REGSEL_W  regbank select.
- reg_rdata  in  DATA_W  regbank read data; combinational from regsel, sampled same cycle.
- reg_val  out  DATA_W  regbank write data.
- reg_we  out  1  regbank write enable.
- alu_op0  out  DATA_W  ALU operand_0.
- alu_op1  out  DATA_W  ALU operand_1.
- alu_opcode  out  OP_W  ALU opcode.
- alu_result  in  DATA_W  ALU result; combinational.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the writeback cycle.
- retire_cnt  out  CNT_W  count of completed writebacks.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0 except op_ready=1; operand, opcode and result latches cleared; retire_cnt=0.
- Reset asserted mid-operation: op abandoned, no write issued, retire_cnt cleared.
- FSM states: IDLE, RD0, RD1, EXEC, WB.
- IDLE:
  - op_ready=1, regsel=0, reg_we=0.
  - On op_valid&op_ready: latch code, dst, src0, src1, imm_en; load B latch with op_imm if imm_en. Next state RD0.
  - op_valid=0: remain in IDLE.
- RD0: regsel=src0; A latch <= reg_rdata. Next state EXEC if imm_en, else RD1.
- RD1: regsel=src1; B latch <= reg_rdata. Next state EXEC.
- EXEC: regsel=dst, reg_we=0; result latch <= alu_result. Next state WB.
- WB: regsel=dst, reg_val=result latch, reg_we=1, done=1; retire_cnt += 1. Next state IDLE.
- alu_op0, alu_op1, alu_opcode are driven registered from the A, B and code latches in all states; alu_result is sampled only in EXEC.
- op_ready=0 in every state except IDLE; op_valid is ignored while busy, and fields are not re-sampled.
- Latency, accept edge to the reg_we cycle: 4 cycles for register ops, 3 for immediate ops. Throughput: one op per 5 cycles (reg) or 4 cycles (imm). No back-to-back acceptance in WB.
- src0==src1 and dst==src0/src1 are legal: reads complete before the write, so the pre-op value is used.
- reg_we is high for exactly one cycle per op; reg_val and regsel are stable for that whole cycle.
- retire_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Widths: all operand paths are DATA_W with no extension or truncation in this block.

Test Plan:
- Reset: hold reset=0 with op_valid=1 -> op_ready=1, busy=0, reg_we=0, retire_cnt=0; no state advance. Release reset -> op accepted on the next edge.
- Reg op: bench ALU op 0 = add; preload r3=0x12, r5=0x30. Issue code=0, dst=7, src0=3, src1=5. Required sequence: regsel 3,5,7,7 in successive cycles; reg_we=1 with reg_val=0x42 exactly 4 cycles after accept; done pulse; retire_cnt=1.
- Imm op: r2=0xF0, imm=0x20, imm_en=1, dst=2 -> RD1 skipped; write r2=0x10 (wrapped) 3 cycles after accept. A following read of r2 returns 0x10.
- Busy hold-off: drive op_valid continuously with changing fields during an op -> op_ready=0 until IDLE; second op uses fields present at its own accept edge; exactly 2 writes.
- Mid-op reset: assert reset=0 during EXEC -> no reg_we pulse; retire_cnt=0; state IDLE.
- Counter wrap: force 65536 immediate ops (or use a CNT_W=4 build with 16 ops) -> retire_cnt returns to 0.
